// File: rtl/cpu64_l1_writeback.sv
// cpu64_l1_writeback
//   Victim/flush writeback engine for the 8-way, 64-set, 64B-line L1 arrays.
//   It reads the addressed line's tag/valid/dirty and its eight data words
//   from the array read ports, buffers the line, and bursts it to memory as
//   one address, eight data beats (word 0 first) and one response. It then
//   clears the dirty bit through a metadata-only array write.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   wb_req_*_i/o          request handshake (index, way); engine accepts only while idle
//   wb_done_o             one-cycle completion pulse, qualifies wb_err_o / wb_skipped_o
//   arr_*_o (addressing)  set index, word select and way select for the array read ports
//   arr_rdata/tag/valid/dirty_i  asynchronous array read data for the selected way
//   arr_write_en_o etc.   metadata rewrite: captured tag, valid=1, dirty=0, no byte enables
//   mem_aw_*              burst address channel, line address {tag, index, 6'b0}
//   mem_w_*               data beats, wlast on the final beat
//   mem_b_*               write response, error flag
module cpu64_l1_writeback #(
  parameter int WAYS   = 8,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int TAG_W  = 52,
  parameter int DATA_W = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wb_req_valid_i,
  output logic                      wb_req_ready_o,
  input  logic [$clog2(SETS)-1:0]   wb_index_i,
  input  logic [$clog2(WAYS)-1:0]   wb_way_i,
  output logic                      wb_done_o,
  output logic                      wb_err_o,
  output logic                      wb_skipped_o,
  output logic [$clog2(SETS)-1:0]   arr_index_o,
  output logic [$clog2(WORDS)-1:0]  arr_word_sel_o,
  output logic [$clog2(WAYS)-1:0]   arr_way_sel_o,
  input  logic [DATA_W-1:0]         arr_rdata_i,
  input  logic [TAG_W-1:0]          arr_tag_i,
  input  logic                      arr_valid_i,
  input  logic                      arr_dirty_i,
  output logic                      arr_write_en_o,
  output logic [DATA_W/8-1:0]       arr_be_o,
  output logic [TAG_W-1:0]          arr_tag_o,
  output logic                      arr_set_valid_o,
  output logic                      arr_set_dirty_o,
  output logic                      mem_aw_valid_o,
  input  logic                      mem_aw_ready_i,
  output logic [63:0]               mem_addr_o,
  output logic                      mem_w_valid_o,
  input  logic                      mem_w_ready_i,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic                      mem_wlast_o,
  input  logic                      mem_b_valid_i,
  input  logic                      mem_b_err_i,
  output logic                      mem_b_ready_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int CNT_W = $clog2(WORDS);
  localparam int OFF_W = $clog2(WORDS * (DATA_W / 8));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_ADDR, S_DATA, S_RESP, S_CLEAN, S_DONE
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_q;
  logic                 skip_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WAY_W-1:0]     way_q;
  logic [TAG_W-1:0]     tag_q;
  logic [DATA_W-1:0]    line_q [WORDS];

  // Control state is reset; the captured index/way/tag and the line buffer
  // are only ever consumed after being written in the same transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wb_req_valid_i) begin
            idx_q   <= wb_index_i;
            way_q   <= wb_way_i;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Only a valid and dirty line needs to reach memory.
          if (!(arr_valid_i && arr_dirty_i)) begin
            skip_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tag_q   <= arr_tag_i;
            cnt_q   <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          line_q[cnt_q] <= arr_rdata_i;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= S_ADDR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ADDR: begin
          if (mem_aw_ready_i) state_q <= S_DATA;
        end
        S_DATA: begin
          // The beat counter also selects wdata, so holding it holds the data.
          if (mem_w_ready_i) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= S_RESP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (mem_b_valid_i) begin
            if (mem_b_err_i) begin
              // Failed write: leave the line dirty so it is not lost.
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CLEAN;
            end
          end
        end
        S_CLEAN: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_req_ready_o  = (state_q == S_IDLE);
  assign wb_done_o       = (state_q == S_DONE);
  assign wb_err_o        = (state_q == S_DONE) && err_q;
  assign wb_skipped_o    = (state_q == S_DONE) && skip_q;

  assign arr_index_o     = idx_q;
  assign arr_way_sel_o   = way_q;
  assign arr_word_sel_o  = cnt_q;

  assign arr_write_en_o  = (state_q == S_CLEAN);
  assign arr_be_o        = '0;
  assign arr_tag_o       = tag_q;
  assign arr_set_valid_o = 1'b1;
  assign arr_set_dirty_o = 1'b0;

  assign mem_aw_valid_o  = (state_q == S_ADDR);
  assign mem_addr_o      = 64'({tag_q, idx_q, {OFF_W{1'b0}}});
  assign mem_w_valid_o   = (state_q == S_DATA);
  assign mem_wdata_o     = line_q[cnt_q];
  assign mem_wlast_o     = (state_q == S_DATA) && (cnt_q == LAST);
  assign mem_b_ready_o   = (state_q == S_RESP);

endmodule

// File: tb/tb_cpu64_l1_writeback.sv
module tb_cpu64_l1_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_index;
  logic [2:0]  req_way;
  logic        done, err_o, skipped;
  logic [5:0]  arr_index;
  logic [2:0]  arr_word_sel, arr_way_sel;
  logic [63:0] arr_rdata;
  logic [51:0] arr_tag;
  logic        arr_valid, arr_dirty;
  logic        arr_we;
  logic [7:0]  arr_be;
  logic [51:0] arr_tag_w;
  logic        arr_set_valid, arr_set_dirty;
  logic        aw_valid, aw_ready;
  logic [63:0] mem_addr;
  logic        w_valid, w_ready;
  logic [63:0] wdata;
  logic        wlast;
  logic        b_valid, b_err, b_ready;

  logic [63:0] words [8];
  assign arr_rdata = words[arr_word_sel];

  int errors = 0;
  int checks = 0;

  // Results of the most recent run_req call.
  int done_cyc, n_aw, n_w, n_wr, n_beats;
  logic r_err, r_skip;

  always #5 clk = ~clk;

  cpu64_l1_writeback dut (
    .clk_i(clk), .rst_i(rst),
    .wb_req_valid_i(req_valid), .wb_req_ready_o(req_ready),
    .wb_index_i(req_index), .wb_way_i(req_way),
    .wb_done_o(done), .wb_err_o(err_o), .wb_skipped_o(skipped),
    .arr_index_o(arr_index), .arr_word_sel_o(arr_word_sel), .arr_way_sel_o(arr_way_sel),
    .arr_rdata_i(arr_rdata), .arr_tag_i(arr_tag), .arr_valid_i(arr_valid), .arr_dirty_i(arr_dirty),
    .arr_write_en_o(arr_we), .arr_be_o(arr_be), .arr_tag_o(arr_tag_w),
    .arr_set_valid_o(arr_set_valid), .arr_set_dirty_o(arr_set_dirty),
    .mem_aw_valid_o(aw_valid), .mem_aw_ready_i(aw_ready), .mem_addr_o(mem_addr),
    .mem_w_valid_o(w_valid), .mem_w_ready_i(w_ready), .mem_wdata_o(wdata), .mem_wlast_o(wlast),
    .mem_b_valid_i(b_valid), .mem_b_err_i(b_err), .mem_b_ready_o(b_ready)
  );

  // Issue one request and follow it cycle by cycle (n = cycles after accept).
  // abort_at >= 0 asserts reset while beat abort_at is being presented.
  task automatic run_req(input logic [5:0] i_idx, input logic [2:0] i_way, input bit stall,
                         input bit berr, input bit hold, input int abort_at);
    int beat;
    bit pend, ready_bad;
    logic [63:0] pw, exp_addr;
    beat = 0; pend = 0; ready_bad = 0; pw = '0;
    done_cyc = -1; n_aw = 0; n_w = 0; n_wr = 0; r_err = 1'bx; r_skip = 1'bx;
    exp_addr = {arr_tag, i_idx, 6'b0};
    @(negedge clk);
    req_valid = 1; req_index = i_idx; req_way = i_way; b_valid = 1; b_err = berr;
    aw_ready = 1; w_ready = 1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    @(posedge clk);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (!hold) req_valid = 0;
      if (req_ready !== 1'b0) ready_bad = 1;
      if (n == 1) begin
        checks++;
        if (arr_index !== i_idx || arr_way_sel !== i_way) begin
          errors++; $display("FAIL arr_select: got idx=%0d way=%0d want idx=%0d way=%0d",
                             arr_index, arr_way_sel, i_idx, i_way);
        end
      end
      if (aw_valid) begin
        n_aw++; checks++;
        if (mem_addr !== exp_addr) begin
          errors++; $display("FAIL mem_addr: got %h want %h", mem_addr, exp_addr);
        end
      end
      if (w_valid) begin
        n_w++; checks++;
        if (wdata !== words[beat] || wlast !== (beat == 7)) begin
          errors++; $display("FAIL beat%0d: got data=%h last=%b want data=%h last=%b",
                             beat, wdata, wlast, words[beat], (beat == 7));
        end
        if (pend) begin
          checks++;
          if (wdata !== pw) begin
            errors++; $display("FAIL wdata_stall: got %h want %h", wdata, pw);
          end
        end
      end
      if (arr_we) begin
        n_wr++; checks++;
        if (arr_be !== 8'h00 || arr_set_dirty !== 1'b0 || arr_set_valid !== 1'b1 || arr_tag_w !== arr_tag) begin
          errors++; $display("FAIL clean_write: got be=%h d=%b v=%b tag=%h want be=00 d=0 v=1 tag=%h",
                             arr_be, arr_set_dirty, arr_set_valid, arr_tag_w, arr_tag);
        end
      end
      if (done) begin
        done_cyc = n; r_err = err_o; r_skip = skipped;
        break;
      end
      if (abort_at >= 0 && w_valid && beat == abort_at) begin
        rst = 1;
        break;
      end
      aw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      pend = w_valid && !w_ready;
      pw   = wdata;
      if (w_valid && w_ready) beat++;
    end
    n_beats = beat;
    checks++;
    if (ready_bad) begin
      errors++; $display("FAIL busy_ready: ready seen high while busy, want 0");
    end
  endtask

  task automatic set_line(input logic [51:0] tag, input logic v, input logic d, input logic [63:0] mult);
    arr_tag = tag; arr_valid = v; arr_dirty = d;
    for (int k = 0; k < 8; k++) words[k] = 64'(k) * mult;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || done !== 0 || err_o !== 0 || skipped !== 0 || arr_we !== 0 ||
        aw_valid !== 0 || w_valid !== 0 || wlast !== 0 || b_ready !== 0 || arr_word_sel !== 3'd0) begin
      errors++; $display("FAIL reset_state: got rdy=%b done=%b aw=%b w=%b last=%b b=%b we=%b cnt=%0d want 1,0,0,0,0,0,0,0",
                         req_ready, done, aw_valid, w_valid, wlast, b_ready, arr_we, arr_word_sel);
    end
    checks++;
    if (arr_be !== 8'h00 || arr_set_valid !== 1'b1 || arr_set_dirty !== 1'b0) begin
      errors++; $display("FAIL reset_consts: got be=%h v=%b d=%b want 00 1 0", arr_be, arr_set_valid, arr_set_dirty);
    end
    rst = 0;
  endtask

  task automatic test_dirty_line;
    set_line(52'hABC, 1, 1, 64'h1111);
    run_req(6'd5, 3'd3, 0, 0, 0, -1);
    checks++;
    if (done_cyc !== 21 || r_err !== 0 || r_skip !== 0) begin
      errors++; $display("FAIL dirty_done: got cyc=%0d err=%b skip=%b want 21 0 0", done_cyc, r_err, r_skip);
    end
    checks++;
    if (n_aw !== 1 || n_w !== 8 || n_beats !== 8 || n_wr !== 1) begin
      errors++; $display("FAIL dirty_counts: got aw=%0d w=%0d beats=%0d wr=%0d want 1 8 8 1", n_aw, n_w, n_beats, n_wr);
    end
  endtask

  task automatic test_clean_line;
    set_line(52'h123, 1, 0, 64'h2222);
    run_req(6'd9, 3'd1, 0, 0, 0, -1);
    checks++;
    if (done_cyc !== 2 || r_skip !== 1 || r_err !== 0) begin
      errors++; $display("FAIL clean_done: got cyc=%0d skip=%b err=%b want 2 1 0", done_cyc, r_skip, r_err);
    end
    checks++;
    if (n_aw !== 0 || n_w !== 0 || n_wr !== 0) begin
      errors++; $display("FAIL clean_traffic: got aw=%0d w=%0d wr=%0d want 0 0 0", n_aw, n_w, n_wr);
    end
    set_line(52'h456, 0, 1, 64'h3333);
    run_req(6'd10, 3'd2, 0, 0, 0, -1);
    checks++;
    if (done_cyc !== 2 || r_skip !== 1 || n_aw !== 0 || n_wr !== 0) begin
      errors++; $display("FAIL invalid_skip: got cyc=%0d skip=%b aw=%0d wr=%0d want 2 1 0 0", done_cyc, r_skip, n_aw, n_wr);
    end
  endtask

  task automatic test_stalls;
    set_line(52'hF_0000_0000_1234, 1, 1, 64'h0101_0202_0303_0405);
    run_req(6'd63, 3'd7, 1, 0, 0, -1);
    checks++;
    if (done_cyc < 21 || r_err !== 0 || r_skip !== 0 || n_beats !== 8 || n_wr !== 1 || n_w < 8) begin
      errors++; $display("FAIL stall_run: got cyc=%0d err=%b skip=%b beats=%0d wr=%0d w=%0d want >=21 0 0 8 1 >=8",
                         done_cyc, r_err, r_skip, n_beats, n_wr, n_w);
    end
  endtask

  task automatic test_bus_error;
    set_line(52'h777, 1, 1, 64'h1111);
    run_req(6'd1, 3'd0, 0, 1, 0, -1);
    checks++;
    if (done_cyc !== 20 || r_err !== 1 || r_skip !== 0 || n_wr !== 0 || n_beats !== 8) begin
      errors++; $display("FAIL bus_error: got cyc=%0d err=%b skip=%b wr=%0d beats=%0d want 20 1 0 0 8",
                         done_cyc, r_err, r_skip, n_wr, n_beats);
    end
  endtask

  task automatic test_reset_mid;
    set_line(52'hABC, 1, 1, 64'h1111);
    run_req(6'd5, 3'd3, 0, 0, 0, 4);
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || aw_valid !== 0 || w_valid !== 0 || b_ready !== 0 || arr_we !== 0 || done !== 0) begin
      errors++; $display("FAIL reset_abort: got rdy=%b aw=%b w=%b b=%b we=%b done=%b want 1 0 0 0 0 0",
                         req_ready, aw_valid, w_valid, b_ready, arr_we, done);
    end
    rst = 0;
    run_req(6'd5, 3'd3, 0, 0, 0, -1);
    checks++;
    if (done_cyc !== 21 || n_beats !== 8 || n_wr !== 1) begin
      errors++; $display("FAIL after_abort: got cyc=%0d beats=%0d wr=%0d want 21 8 1", done_cyc, n_beats, n_wr);
    end
  endtask

  task automatic test_back_to_back;
    set_line(52'hBEEF, 1, 1, 64'h1010);
    run_req(6'd20, 3'd4, 0, 0, 1, -1);
    checks++;
    if (done_cyc !== 21 || req_ready !== 0) begin
      errors++; $display("FAIL b2b_first: got cyc=%0d ready_at_done=%b want 21 0", done_cyc, req_ready);
    end
    run_req(6'd21, 3'd5, 0, 0, 0, -1);
    checks++;
    if (done_cyc !== 21 || n_beats !== 8 || r_err !== 0) begin
      errors++; $display("FAIL b2b_second: got cyc=%0d beats=%0d err=%b want 21 8 0", done_cyc, n_beats, r_err);
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_index = '0; req_way = '0;
    aw_ready = 1; w_ready = 1; b_valid = 0; b_err = 0;
    set_line(52'h0, 0, 0, 64'h0);
    test_reset;
    test_dirty_line;
    test_clean_line;
    test_stalls;
    test_bus_error;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
